// File: rtl/ch0re_lsu_if.sv
// ch0re_lsu_if: groups the EX->LSU op handshake, the dword data-memory port
// and the LSU->WB completion into one bundle.
//   EX side : i_valid, o_ready, i_lsu_op, i_dtype, i_addr, i_wdata, i_rd
//   MEM side: o_mem_req, i_mem_gnt, o_mem_addr, o_mem_we, o_mem_be,
//             o_mem_wdata, i_mem_rvalid, i_mem_rdata
//   WB side : o_wb_valid, o_wb_wen, o_wb_rd, o_wb_data, o_misaligned
// Signal names keep the i_/o_ prefixes as seen from the LSU; the slave
// modport is the LSU view, the master modport is the EX/MEM/WB environment.
interface ch0re_lsu_if #(
    parameter int unsigned MEM_ADDR_WIDTH = 12
);
    logic                      i_valid;
    logic                      o_ready;
    logic [1:0]                i_lsu_op;
    logic [2:0]                i_dtype;
    logic [63:0]               i_addr;
    logic [63:0]               i_wdata;
    logic [4:0]                i_rd;

    logic                      o_mem_req;
    logic                      i_mem_gnt;
    logic [MEM_ADDR_WIDTH-1:0] o_mem_addr;
    logic                      o_mem_we;
    logic [7:0]                o_mem_be;
    logic [63:0]               o_mem_wdata;
    logic                      i_mem_rvalid;
    logic [63:0]               i_mem_rdata;

    logic                      o_wb_valid;
    logic                      o_wb_wen;
    logic [4:0]                o_wb_rd;
    logic [63:0]               o_wb_data;
    logic                      o_misaligned;

    modport slave (
        input  i_valid, i_lsu_op, i_dtype, i_addr, i_wdata, i_rd,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        output o_ready,
        output o_mem_req, o_mem_addr, o_mem_we, o_mem_be, o_mem_wdata,
        output o_wb_valid, o_wb_wen, o_wb_rd, o_wb_data, o_misaligned
    );

    modport master (
        output i_valid, i_lsu_op, i_dtype, i_addr, i_wdata, i_rd,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        input  o_ready,
        input  o_mem_req, o_mem_addr, o_mem_we, o_mem_be, o_mem_wdata,
        input  o_wb_valid, o_wb_wen, o_wb_rd, o_wb_data, o_misaligned
    );
endinterface

// File: rtl/ch0re_lsu.sv
// ch0re_lsu: load/store unit of the ch0re RV64I core, between EX and WB.
// Accepts one LOAD/STORE per handshake, drives a req/gnt/rvalid dword data
// memory port with byte enables and lane-shifted store data, extracts and
// sign/zero-extends load data, and flags misaligned accesses. Every accepted
// LOAD/STORE produces exactly one registered o_wb_valid pulse.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   lsu        : ch0re_lsu_if.slave (EX handshake, memory port, WB result)
module ch0re_lsu #(
    parameter int unsigned MEM_ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    ch0re_lsu_if.slave  lsu
);

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned BE_W    = 8;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned DTYPE_W = 3;

    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;

    localparam logic [DTYPE_W-1:0] DT_B  = 3'd0;
    localparam logic [DTYPE_W-1:0] DT_H  = 3'd1;
    localparam logic [DTYPE_W-1:0] DT_W  = 3'd2;
    localparam logic [DTYPE_W-1:0] DT_BU = 3'd4;
    localparam logic [DTYPE_W-1:0] DT_HU = 3'd5;
    localparam logic [DTYPE_W-1:0] DT_WU = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t               state;
    logic [DTYPE_W-1:0]   dtype_q;
    logic [2:0]           sh_q;
    logic                 is_load_q;
    logic                 fault_q;
    logic [REG_W-1:0]     rd_q;

    logic                 accept_c;
    logic                 is_load_c;
    logic                 misaligned_c;
    logic [BE_W-1:0]      be_base_c;
    logic [BE_W-1:0]      be_c;
    logic [DATA_W-1:0]    st_data_c;
    logic [DATA_W-1:0]    ld_shift_c;
    logic [DATA_W-1:0]    ld_ext_c;
    logic                 unused_addr_hi_c;

    // Only the dword index of the byte address reaches memory.
    assign unused_addr_hi_c = ^lsu.i_addr[DATA_W-1:MEM_ADDR_WIDTH+3];

    // Accept decode, alignment check and store lane generation on EX inputs.
    always_comb begin
        accept_c     = lsu.i_valid && lsu.o_ready &&
                       ((lsu.i_lsu_op == OP_LOAD) || (lsu.i_lsu_op == OP_STORE));
        is_load_c    = (lsu.i_lsu_op == OP_LOAD);
        misaligned_c = 1'b0;
        be_base_c    = 8'hFF;
        case (lsu.i_dtype)
            DT_B, DT_BU: begin
                misaligned_c = 1'b0;
                be_base_c    = 8'h01;
            end
            DT_H, DT_HU: begin
                misaligned_c = lsu.i_addr[0];
                be_base_c    = 8'h03;
            end
            DT_W, DT_WU: begin
                misaligned_c = |lsu.i_addr[1:0];
                be_base_c    = 8'h0F;
            end
            // D and the illegal encoding 7 are both treated as dword accesses.
            default: begin
                misaligned_c = |lsu.i_addr[2:0];
                be_base_c    = 8'hFF;
            end
        endcase
        be_c      = be_base_c << lsu.i_addr[2:0];
        st_data_c = lsu.i_wdata << {lsu.i_addr[2:0], 3'b000};
    end

    // Load data alignment and extension from the latched access shape.
    always_comb begin
        ld_shift_c = lsu.i_mem_rdata >> {sh_q, 3'b000};
        case (dtype_q)
            DT_B:    ld_ext_c = {{56{ld_shift_c[7]}},  ld_shift_c[7:0]};
            DT_H:    ld_ext_c = {{48{ld_shift_c[15]}}, ld_shift_c[15:0]};
            DT_W:    ld_ext_c = {{32{ld_shift_c[31]}}, ld_shift_c[31:0]};
            DT_BU:   ld_ext_c = {56'd0, ld_shift_c[7:0]};
            DT_HU:   ld_ext_c = {48'd0, ld_shift_c[15:0]};
            DT_WU:   ld_ext_c = {32'd0, ld_shift_c[31:0]};
            default: ld_ext_c = ld_shift_c;
        endcase
    end

    // Control FSM with registered memory and write-back outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            dtype_q          <= '0;
            sh_q             <= '0;
            is_load_q        <= 1'b0;
            fault_q          <= 1'b0;
            rd_q             <= '0;
            lsu.o_ready      <= 1'b1;
            lsu.o_mem_req    <= 1'b0;
            lsu.o_mem_addr   <= '0;
            lsu.o_mem_we     <= 1'b0;
            lsu.o_mem_be     <= '0;
            lsu.o_mem_wdata  <= '0;
            lsu.o_wb_valid   <= 1'b0;
            lsu.o_wb_wen     <= 1'b0;
            lsu.o_wb_rd      <= '0;
            lsu.o_wb_data    <= '0;
            lsu.o_misaligned <= 1'b0;
        end else begin
            lsu.o_wb_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        // A faulting op skips the memory port but still spends
                        // one REQ slot, so it completes on the same cycle a
                        // store granted immediately would.
                        state          <= S_REQ;
                        lsu.o_ready    <= 1'b0;
                        dtype_q        <= lsu.i_dtype;
                        sh_q           <= lsu.i_addr[2:0];
                        is_load_q      <= is_load_c;
                        fault_q        <= misaligned_c;
                        rd_q           <= lsu.i_rd;
                        lsu.o_mem_req  <= !misaligned_c;
                        lsu.o_mem_addr <= lsu.i_addr[MEM_ADDR_WIDTH+2:3];
                        lsu.o_mem_we   <= !is_load_c && !misaligned_c;
                        lsu.o_mem_be   <= (!is_load_c && !misaligned_c) ? be_c : '0;
                        lsu.o_mem_wdata <= (!is_load_c && !misaligned_c) ? st_data_c : '0;
                    end
                end
                S_REQ: begin
                    if (fault_q) begin
                        state            <= S_RESP;
                        lsu.o_wb_valid   <= 1'b1;
                        lsu.o_wb_wen     <= 1'b0;
                        lsu.o_wb_rd      <= rd_q;
                        lsu.o_wb_data    <= '0;
                        lsu.o_misaligned <= 1'b1;
                    end else if (lsu.i_mem_gnt) begin
                        lsu.o_mem_req   <= 1'b0;
                        lsu.o_mem_we    <= 1'b0;
                        lsu.o_mem_be    <= '0;
                        lsu.o_mem_wdata <= '0;
                        if (is_load_q) begin
                            state <= S_WAIT;
                        end else begin
                            state            <= S_RESP;
                            lsu.o_wb_valid   <= 1'b1;
                            lsu.o_wb_wen     <= 1'b0;
                            lsu.o_wb_rd      <= rd_q;
                            lsu.o_wb_data    <= '0;
                            lsu.o_misaligned <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (lsu.i_mem_rvalid) begin
                        state            <= S_RESP;
                        lsu.o_wb_valid   <= 1'b1;
                        lsu.o_wb_wen     <= (rd_q != 5'd0);
                        lsu.o_wb_rd      <= rd_q;
                        lsu.o_wb_data    <= ld_ext_c;
                        lsu.o_misaligned <= 1'b0;
                    end
                end
                default: begin
                    // RESP: the pulse drops via the default above; reopen EX.
                    state            <= S_IDLE;
                    lsu.o_ready      <= 1'b1;
                    lsu.o_wb_wen     <= 1'b0;
                    lsu.o_wb_rd      <= '0;
                    lsu.o_wb_data    <= '0;
                    lsu.o_misaligned <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ch0re_lsu.sv
// tb_ch0re_lsu: directed scoreboard bench for ch0re_lsu. Stimulus pushes the
// expected memory request and write-back result; a memory responder and a
// write-back monitor pop and compare. Cycle k+1 starts at rising edge k, so a
// write-back expected "lat" edges after the accept edge is seen at the
// falling edge where the edge counter equals accept_edge + lat.
module tb_ch0re_lsu;
    localparam int unsigned MAW = 12;
    localparam logic [63:0] MEMD = 64'hDEADBEEF_CAFEF00D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ch0re_lsu_if #(.MEM_ADDR_WIDTH(MAW)) bus();
    ch0re_lsu #(.MEM_ADDR_WIDTH(MAW)) dut (.clk(clk), .rst_n(rst_n), .lsu(bus));

    typedef struct {
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] data;
        logic        mis;
        int          cyc;
    } wb_exp_t;

    typedef struct {
        logic [MAW-1:0] addr;
        logic           we;
        logic [7:0]     be;
        logic [63:0]    wdata;
    } mem_exp_t;

    wb_exp_t  sb[$];
    mem_exp_t mq[$];
    wb_exp_t  mon_e;
    mem_exp_t rsp_e;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit auto_mem = 1'b0;
    int gnt_dly = 0;
    int rv_dly = 1;
    logic [63:0] mem_rdata = MEMD;
    logic auto_gnt = 1'b0, auto_rvalid = 1'b0;
    logic man_gnt = 1'b0, man_rvalid = 1'b0;

    assign bus.i_mem_gnt    = auto_gnt | man_gnt;
    assign bus.i_mem_rvalid = auto_rvalid | man_rvalid;
    assign bus.i_mem_rdata  = mem_rdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Write-back monitor: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.o_wb_valid === 1'b1) begin
            chk("wb_pulse_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("wb_rd",   64'(bus.o_wb_rd),      64'(mon_e.rd));
                chk("wb_wen",  64'(bus.o_wb_wen),     64'(mon_e.wen));
                chk("wb_data", bus.o_wb_data,          mon_e.data);
                chk("wb_mis",  64'(bus.o_misaligned), 64'(mon_e.mis));
                chk("wb_cycle", 64'(cyc),             64'(mon_e.cyc));
            end
        end
    end

    // Memory responder: checks each request, grants after gnt_dly cycles,
    // returns load data rv_dly cycles after the grant.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_mem && rst_n && bus.o_mem_req === 1'b1) begin
                chk("mem_req_expected", 64'(mq.size() != 0), 64'd1);
                if (mq.size() != 0) begin
                    rsp_e = mq.pop_front();
                    chk("mem_addr",  64'(bus.o_mem_addr), 64'(rsp_e.addr));
                    chk("mem_we",    64'(bus.o_mem_we),   64'(rsp_e.we));
                    chk("mem_be",    64'(bus.o_mem_be),   64'(rsp_e.be));
                    chk("mem_wdata", bus.o_mem_wdata,     rsp_e.wdata);
                    for (int k = 0; k < gnt_dly; k++) begin
                        chk("ready_low_req", 64'(bus.o_ready),    64'd0);
                        chk("req_held",      64'(bus.o_mem_req),  64'd1);
                        chk("addr_stable",   64'(bus.o_mem_addr), 64'(rsp_e.addr));
                        chk("be_stable",     64'(bus.o_mem_be),   64'(rsp_e.be));
                        @(negedge clk);
                    end
                    auto_gnt = 1'b1;
                    @(negedge clk);
                    auto_gnt = 1'b0;
                    if (!rsp_e.we) begin
                        for (int k = 1; k < rv_dly; k++) begin
                            chk("ready_low_wait", 64'(bus.o_ready), 64'd0);
                            @(negedge clk);
                        end
                        auto_rvalid = 1'b1;
                        @(negedge clk);
                        auto_rvalid = 1'b0;
                    end
                end
            end
        end
    end

    // Issue one op; mem=1 means a memory request is expected.
    task automatic issue(input logic [1:0] op, input logic [2:0] dt, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [4:0] rd, input logic mem,
                         input logic [7:0] be, input logic [63:0] mwdata,
                         input logic [63:0] xdata, input logic xwen, input logic xmis);
        int n;
        int lat;
        wb_exp_t  we;
        mem_exp_t me;
        @(negedge clk);
        n = 0;
        while (bus.o_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 64'(bus.o_ready), 64'd1);
        if (!mem)              lat = 1;
        else if (op == 2'd1)   lat = 1 + gnt_dly + rv_dly;
        else                   lat = 1 + gnt_dly;
        if (mem) begin
            me.addr  = addr[MAW+2:3];
            me.we    = (op == 2'd2);
            me.be    = be;
            me.wdata = mwdata;
            mq.push_back(me);
        end
        we.rd   = rd;
        we.wen  = xwen;
        we.data = xdata;
        we.mis  = xmis;
        we.cyc  = cyc + 1 + lat;
        sb.push_back(we);
        bus.i_lsu_op = op;
        bus.i_dtype  = dt;
        bus.i_addr   = addr;
        bus.i_wdata  = wdata;
        bus.i_rd     = rd;
        bus.i_valid  = 1'b1;
        @(negedge clk);
        bus.i_valid  = 1'b0;
        bus.i_lsu_op = 2'd0;
    endtask

    task automatic ld(input logic [2:0] dt, input logic [63:0] addr, input logic [4:0] rd,
                      input logic [63:0] xdata, input logic xwen);
        issue(2'd1, dt, addr, 64'h5555_5555_5555_5555, rd, 1'b1, 8'h00, 64'd0, xdata, xwen, 1'b0);
    endtask

    task automatic st(input logic [2:0] dt, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [4:0] rd, input logic [7:0] be, input logic [63:0] mwdata);
        issue(2'd2, dt, addr, wdata, rd, 1'b1, be, mwdata, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic mis(input logic [1:0] op, input logic [2:0] dt, input logic [63:0] addr,
                       input logic [4:0] rd);
        issue(op, dt, addr, 64'hFFFF_FFFF_FFFF_FFFF, rd, 1'b0, 8'h00, 64'd0, 64'd0, 1'b0, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(bus.o_ready === 1'b1 && sb.size() == 0 && mq.size() == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size() + mq.size()), 64'd0);
    endtask

    initial begin
        bus.i_valid  = 1'b0;
        bus.i_lsu_op = 2'd0;
        bus.i_dtype  = 3'd0;
        bus.i_addr   = 64'd0;
        bus.i_wdata  = 64'd0;
        bus.i_rd     = 5'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready",    64'(bus.o_ready),      64'd1);
        chk("rst_req",      64'(bus.o_mem_req),    64'd0);
        chk("rst_be",       64'(bus.o_mem_be),     64'd0);
        chk("rst_wb_valid", 64'(bus.o_wb_valid),   64'd0);
        chk("rst_wb_data",  bus.o_wb_data,          64'd0);
        chk("rst_mis",      64'(bus.o_misaligned), 64'd0);
        rst_n = 1'b1;
        auto_mem = 1'b1;

        // Loads from dword 2 holding DEADBEEF_CAFEF00D, back to back.
        ld(3'd2, 64'h14, 5'd5,  64'hFFFFFFFF_DEADBEEF, 1'b1);
        ld(3'd4, 64'h13, 5'd6,  64'h00000000_000000CA, 1'b1);
        ld(3'd0, 64'h13, 5'd7,  64'hFFFFFFFF_FFFFFFCA, 1'b1);
        ld(3'd5, 64'h16, 5'd8,  64'h00000000_0000DEAD, 1'b1);
        ld(3'd1, 64'h12, 5'd9,  64'hFFFFFFFF_FFFFCAFE, 1'b1);
        ld(3'd3, 64'h10, 5'd10, MEMD,                  1'b1);
        ld(3'd6, 64'h10, 5'd11, 64'h00000000_CAFEF00D, 1'b1);
        ld(3'd2, 64'h10, 5'd12, 64'hFFFFFFFF_CAFEF00D, 1'b1);
        ld(3'd0, 64'h17, 5'd15, 64'hFFFFFFFF_FFFFFFDE, 1'b1);
        ld(3'd7, 64'h10, 5'd14, MEMD,                  1'b1);
        ld(3'd2, 64'h14, 5'd0,  64'hFFFFFFFF_DEADBEEF, 1'b0);
        ld(3'd3, 64'hFFFF_0000_0000_7FF8, 5'd16, MEMD, 1'b1);

        // Stores: lane enables and shifted data.
        st(3'd1, 64'h06, 64'h1234,                5'd3, 8'hC0, 64'h1234_0000_0000_0000);
        st(3'd0, 64'h0B, 64'hFFA5,                5'd0, 8'h08, 64'h0000_00FF_A500_0000);
        st(3'd2, 64'h1C, 64'h11223344,            5'd1, 8'hF0, 64'h11223344_00000000);
        st(3'd3, 64'h20, 64'h01234567_89ABCDEF,   5'd2, 8'hFF, 64'h01234567_89ABCDEF);

        // Misaligned: no memory request, fault completion.
        mis(2'd1, 3'd3, 64'h0C, 5'd4);
        mis(2'd1, 3'd2, 64'h12, 5'd5);
        mis(2'd2, 3'd1, 64'h01, 5'd6);
        mis(2'd1, 3'd7, 64'h14, 5'd7);
        mis(2'd1, 3'd5, 64'h15, 5'd8);

        // NONE op produces nothing and leaves the LSU ready.
        wait_idle();
        @(negedge clk);
        bus.i_lsu_op = 2'd0;
        bus.i_valid  = 1'b1;
        @(negedge clk);
        bus.i_valid  = 1'b0;
        chk("none_ready", 64'(bus.o_ready),   64'd1);
        chk("none_req",   64'(bus.o_mem_req), 64'd0);

        // Slow memory: grant after 3 cycles, data 4 cycles after grant.
        wait_idle();
        gnt_dly = 3;
        rv_dly  = 4;
        ld(3'd3, 64'h10, 5'd17, MEMD, 1'b1);
        st(3'd3, 64'h18, 64'hA5A5, 5'd1, 8'hFF, 64'hA5A5);
        wait_idle();
        gnt_dly = 0;
        rv_dly  = 1;

        // Reset while waiting for load data; the late rvalid must be ignored.
        auto_mem = 1'b0;
        @(negedge clk);
        bus.i_lsu_op = 2'd1;
        bus.i_dtype  = 3'd3;
        bus.i_addr   = 64'h10;
        bus.i_rd     = 5'd13;
        bus.i_valid  = 1'b1;
        @(negedge clk);
        bus.i_valid  = 1'b0;
        bus.i_lsu_op = 2'd0;
        chk("rst_test_req", 64'(bus.o_mem_req), 64'd1);
        man_gnt = 1'b1;
        @(negedge clk);
        man_gnt = 1'b0;
        chk("rst_test_wait_ready", 64'(bus.o_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_ready", 64'(bus.o_ready),   64'd1);
        chk("rst_mid_req",   64'(bus.o_mem_req), 64'd0);
        man_rvalid = 1'b1;
        @(negedge clk);
        man_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_rvalid_ready", 64'(bus.o_ready),    64'd1);
        chk("late_rvalid_wb",    64'(bus.o_wb_valid), 64'd0);
        auto_mem = 1'b1;
        ld(3'd2, 64'h14, 5'd5, 64'hFFFFFFFF_DEADBEEF, 1'b1);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got edge %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
